// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/ALU constants, the control bundle and its width.
package decode_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBgtz  = 6'h07;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpLhu   = 6'h25;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type function codes that need special handling
  localparam logic [5:0] FnJr = 6'h08;

  // ALU operations reuse the R-type funct encoding; LUI gets a private code
  localparam logic [5:0] AluAdd  = 6'h20;
  localparam logic [5:0] AluAddu = 6'h21;
  localparam logic [5:0] AluSub  = 6'h22;
  localparam logic [5:0] AluSlt  = 6'h2A;
  localparam logic [5:0] AluLui  = 6'h3F;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    logic [5:0] alu_op;
    logic [1:0] access_size;
    logic       byte_s;    // sign-extend sub-word load data
    logic       alu_in_b;  // ALU operand B is the immediate
    logic       d_mem_we;
    logic       rwd;       // write-back data comes from memory
    logic       br;
    logic       jp;
    logic       g_t;       // branch on greater-than-zero
    logic       sign_x;
    logic       nop;
    logic       mem_op;
    logic       link;
    logic       rwe;
    logic       r_dst;
    logic       uses_rt;
    logic       is_load;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Memory access size from the low opcode bits (x0 byte, x1 half, x3 word)
  function automatic logic [1:0] mem_size(input logic [5:0] op);
    if (op[1:0] == 2'b11) return SizeWord;
    return op[0] ? SizeHalf : SizeByte;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: register fields, extended immediate, control bundle.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       instr_i,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] imm_o,
  output ctrl_t             ctrl_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_nop;

  assign op     = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign is_nop = (instr_i == 32'h0);
  assign rs_o   = instr_i[25:21];
  assign rt_o   = instr_i[20:16];
  assign rd_o   = instr_i[15:11];

  // Opcode to control bundle; unknown opcodes decode to an inert bundle
  always_comb begin
    ctrl_o     = '0;
    ctrl_o.nop = is_nop;
    case (op)
      OpRtype: begin
        if (funct == FnJr) begin
          ctrl_o.jp = 1'b1;
        end else begin
          ctrl_o.alu_op  = funct;
          ctrl_o.r_dst   = 1'b1;
          ctrl_o.uses_rt = 1'b1;
          ctrl_o.rwe     = !is_nop;
        end
      end
      OpJ: ctrl_o.jp = 1'b1;
      OpJal: begin
        ctrl_o.jp   = 1'b1;
        ctrl_o.link = 1'b1;
        ctrl_o.rwe  = 1'b1;
      end
      OpBeq: begin
        ctrl_o.br      = 1'b1;
        ctrl_o.uses_rt = 1'b1;
        ctrl_o.sign_x  = 1'b1;
        ctrl_o.alu_op  = AluSub;
      end
      OpBgtz: begin
        ctrl_o.br     = 1'b1;
        ctrl_o.g_t    = 1'b1;
        ctrl_o.sign_x = 1'b1;
        ctrl_o.alu_op = AluSlt;
      end
      OpAddi, OpAddiu, OpSlti: begin
        ctrl_o.rwe      = 1'b1;
        ctrl_o.alu_in_b = 1'b1;
        ctrl_o.sign_x   = 1'b1;
        ctrl_o.alu_op   = (op == OpAddi) ? AluAdd : (op == OpAddiu) ? AluAddu : AluSlt;
      end
      OpAndi, OpOri, OpXori: begin
        ctrl_o.rwe      = 1'b1;
        ctrl_o.alu_in_b = 1'b1;
        // andi/ori/xori low opcode bits line up with funct 0x24/0x25/0x26
        ctrl_o.alu_op   = {4'b1001, op[1:0]};
      end
      OpLui: begin
        ctrl_o.rwe      = 1'b1;
        ctrl_o.alu_in_b = 1'b1;
        ctrl_o.alu_op   = AluLui;
      end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        ctrl_o.rwe         = 1'b1;
        ctrl_o.alu_in_b    = 1'b1;
        ctrl_o.sign_x      = 1'b1;
        ctrl_o.mem_op      = 1'b1;
        ctrl_o.rwd         = 1'b1;
        ctrl_o.is_load     = 1'b1;
        ctrl_o.alu_op      = AluAdd;
        ctrl_o.access_size = mem_size(op);
        ctrl_o.byte_s      = !op[2];
      end
      OpSb, OpSh, OpSw: begin
        ctrl_o.d_mem_we    = 1'b1;
        ctrl_o.mem_op      = 1'b1;
        ctrl_o.alu_in_b    = 1'b1;
        ctrl_o.sign_x      = 1'b1;
        ctrl_o.uses_rt     = 1'b1;
        ctrl_o.alu_op      = AluAdd;
        ctrl_o.access_size = mem_size(op);
      end
      default: ;
    endcase
  end

  assign imm_o = ctrl_o.sign_x ? {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]}
                               : {{(DATA_W-16){1'b0}}, instr_i[15:0]};

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file, load scoreboard, valid/ready handshake and output register.
// Optional build macro DECODE_WB_BYPASS_EN forwards same-cycle write-back data to operands
// and lets that write-back release a scoreboard stall in the same cycle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned SP_IDX   = 29,
  parameter logic [31:0] SP_RESET = 32'h7FFF_FFF0,
  parameter int unsigned LINK_IDX = NUM_REGS - 1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_s1,
  output logic [DATA_W-1:0] out_s2,
  output logic [DATA_W-1:0] out_imm,
  output logic [AW-1:0]     out_dest,
  output ctrl_t             out_ctrl,
  output logic [DATA_W-1:0] stack_pointer
);

  localparam logic [AW-1:0] SpAddr   = AW'(SP_IDX);
  localparam logic [AW-1:0] LinkAddr = AW'(LINK_IDX);

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] imm;
    logic [AW-1:0]     dest;
    ctrl_t             ctrl;
  } bundle_t;

  logic [4:0]        rs_f, rt_f, rd_f;
  logic [DATA_W-1:0] imm;
  ctrl_t             ctrl;
  logic [AW-1:0]     rs, rt, rd, dest;
  logic [DATA_W-1:0] s1_val, s2_val;
  logic              s1_busy, s2_busy, stall, xfer;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  bundle_t           bundle_q, bundle_d;

  instr_decoder #(
    .DATA_W(DATA_W)
  ) u_dec (
    .instr_i(instruction),
    .rs_o   (rs_f),
    .rt_o   (rt_f),
    .rd_o   (rd_f),
    .imm_o  (imm),
    .ctrl_o (ctrl)
  );

  assign rs   = AW'(rs_f);
  assign rt   = AW'(rt_f);
  assign rd   = AW'(rd_f);
  assign dest = ctrl.link ? LinkAddr : (ctrl.r_dst ? rd : rt);

  // Operand read; register 0 is hard-wired to zero
  always_comb begin
    s1_val = (rs == '0) ? '0 : rf_q[rs];
    s2_val = (rt == '0) ? '0 : rf_q[rt];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == rs && rs != '0) s1_val = wb_data;
    if (wb_en && wb_addr == rt && rt != '0) s2_val = wb_data;
`endif
  end

  // Hazard check: s1 is always treated as read, rt only when the instruction uses it
  always_comb begin
    s1_busy = busy_q[rs];
    s2_busy = busy_q[rt] && ctrl.uses_rt;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == rs) s1_busy = 1'b0;
    if (wb_en && wb_addr == rt) s2_busy = 1'b0;
`endif
    stall = s1_busy || s2_busy;
  end

  assign in_ready = !stall && (!out_valid_q || out_ready);
  // flush discards an instruction even if the handshake completed
  assign xfer     = in_valid && in_ready && !flush;

  // Register file write-back; writes to register 0 are dropped
  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_addr != '0) rf_d[wb_addr] = wb_data;
  end

  // Scoreboard: load issue sets the busy bit, write-back clears it, set wins on collision
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (xfer && ctrl.is_load && dest != '0) busy_d[dest] = 1'b1;
  end

  // Output register: load on transfer, hold while stalled downstream, drop on flush
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d   = 1'b1;
      bundle_d.pc   = pc;
      bundle_d.s1   = s1_val;
      bundle_d.s2   = s2_val;
      bundle_d.imm  = imm;
      bundle_d.dest = dest;
      bundle_d.ctrl = ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State update with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      busy_q      <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i[AW-1:0]] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      busy_q      <= busy_d;
      rf_q        <= rf_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = bundle_q.pc;
  assign out_s1        = bundle_q.s1;
  assign out_s2        = bundle_q.s2;
  assign out_imm       = bundle_q.imm;
  assign out_dest      = bundle_q.dest;
  assign out_ctrl      = bundle_q.ctrl;
  assign stack_pointer = rf_q[SpAddr];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of registers, busy set and output slot.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned NR = 32;
  localparam logic [31:0] SP_RST = 32'h7FFF_FFF0;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] pc, instruction, wb_data, out_pc, out_s1, out_s2, out_imm, stack_pointer;
  logic [4:0]  wb_addr, out_dest;
  ctrl_t       out_ctrl;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc           (pc),
    .instruction  (instruction),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_s1       (out_s1),
    .out_s2       (out_s2),
    .out_imm      (out_imm),
    .out_dest     (out_dest),
    .out_ctrl     (out_ctrl),
    .stack_pointer(stack_pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  logic [31:0]   m_rf [NR];
  logic [NR-1:0] m_busy;
  logic          m_valid;
  logic [31:0]   m_pc, m_s1, m_s2, m_imm;
  logic [4:0]    m_dest;
  logic          m_nop, m_load, m_link;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        uses_rt;
    logic        is_load;
    logic        nop;
    logic        link;
    logic [31:0] imm;
  } ref_t;

  // Instruction meaning from the ISA tables, independent of any hardware structure
  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    logic [5:0] op;
    op        = ins[31:26];
    r.rs      = ins[25:21];
    r.rt      = ins[20:16];
    r.link    = (op == 6'h03);
    r.is_load = (op == 6'h23) || (op == 6'h20);
    r.uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    r.nop     = (ins == 32'h0);
    r.dest    = r.link ? 5'd31 : ((op == 6'h00) ? ins[15:11] : ins[20:16]);
    if (op == 6'h08 || op == 6'h23 || op == 6'h20 || op == 6'h2B || op == 6'h04)
      r.imm = {{16{ins[15]}}, ins[15:0]};
    else
      r.imm = {16'h0, ins[15:0]};
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic logic m_src_blocked(input logic [4:0] a);
    if (!m_busy[a]) return 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic m_ready();
    ref_t r;
    logic stall;
    r     = ref_decode(instruction);
    stall = m_src_blocked(r.rs) || (r.uses_rt && m_src_blocked(r.rt));
    return !stall && (!m_valid || out_ready);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = 32'h0;
    m_rf[29] = SP_RST;
    m_busy   = '0;
    m_valid  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle
  task automatic model_step();
    ref_t r;
    logic xfer;
    r    = ref_decode(instruction);
    xfer = in_valid && m_ready() && !flush;
    if (flush) begin
      m_valid = 1'b0;
    end else if (xfer) begin
      m_valid = 1'b1;
      m_pc    = pc;
      m_s1    = m_read(r.rs);
      m_s2    = m_read(r.rt);
      m_imm   = r.imm;
      m_dest  = r.dest;
      m_nop   = r.nop;
      m_load  = r.is_load;
      m_link  = r.link;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en) begin
      m_busy[wb_addr] = 1'b0;
      if (wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    end
    if (xfer && r.is_load && r.dest != 5'd0) m_busy[r.dest] = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("stack_pointer", stack_pointer, m_rf[29]);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_s1", out_s1, m_s1);
      chk("out_s2", out_s2, m_s2);
      chk("out_imm", out_imm, m_imm);
      chk("out_dest", 32'(out_dest), 32'(m_dest));
      chk("ctrl_nop", 32'(out_ctrl.nop), 32'(m_nop));
      chk("ctrl_is_load", 32'(out_ctrl.is_load), 32'(m_load));
      chk("ctrl_link", 32'(out_ctrl.link), 32'(m_link));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] d, input logic [4:0] s,
                                        input logic [4:0] t, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                       input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
    in_valid    = iv;
    pc          = p;
    instruction = ins;
    flush       = fl;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    out_ready   = ordy;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic clock();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_wb_addr();
    if (m_busy != '0 && $urandom_range(0, 1) == 1) begin
      for (int i = 0; i < NR; i++) if (m_busy[i]) return 5'(i);
    end
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [15:0] im;
    a  = 5'($urandom_range(0, 7));
    b  = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       return enc_r(d, a, b, 6'h20);
      1:       return enc_r(d, a, b, 6'h22);
      2:       return enc_i(6'h08, a, b, im);
      3:       return enc_i(6'h0D, a, b, im);
      4:       return enc_i(6'h23, a, b, im);
      5:       return enc_i(6'h20, a, b, im);
      6:       return enc_i(6'h2B, a, b, im);
      7:       return enc_i(6'h04, a, b, im);
      8:       return {6'h03, 26'($urandom)};
      default: return 32'h0;
    endcase
  endfunction

  localparam logic [5:0] FnAdd = 6'h20;

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset release
    settle();
    chk("rst_sp", stack_pointer, 32'h7FFF_FFF0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_ctrl", 32'(out_ctrl), 32'h0);
    drive(1'b1, 32'h100, enc_r(5'd9, 5'd5, 5'd0, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("r5_reads_zero", out_s1, 32'h0);

    // Write-back then consumer reads the new value
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd8, 32'h1234, 1'b1);
    settle();
    clock();
    drive(1'b1, 32'h104, enc_r(5'd9, 5'd8, 5'd8, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("wb_s1", out_s1, 32'h1234);
    chk("wb_s2", out_s2, 32'h1234);
    chk("wb_dest", 32'(out_dest), 32'd9);

    // Load-use hazard: lw r4,0(r2) then add r5,r4,r1
    drive(1'b1, 32'h108, enc_i(OpLw, 5'd2, 5'd4, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("lw_is_load", 32'(out_ctrl.is_load), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h10C, enc_r(5'd5, 5'd4, 5'd1, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      settle();
      chk("lu_stall", 32'(in_ready), 32'd0);
      clock();
    end
    drive(1'b1, 32'h10C, enc_r(5'd5, 5'd4, 5'd1, FnAdd), 1'b0, 1'b1, 5'd4, 32'hAA, 1'b1);
    settle();
`ifdef DECODE_WB_BYPASS_EN
    chk("lu_ready_wb_cycle", 32'(in_ready), 32'd1);
    clock();
    chk("lu_bypass_s1", out_s1, 32'hAA);
`else
    chk("lu_stall_wb_cycle", 32'(in_ready), 32'd0);
    clock();
    drive(1'b1, 32'h10C, enc_r(5'd5, 5'd4, 5'd1, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    chk("lu_ready_after", 32'(in_ready), 32'd1);
    clock();
    chk("lu_s1", out_s1, 32'hAA);
`endif

    // Downstream back-pressure for three cycles
    drive(1'b1, 32'h200, enc_i(OpAddi, 5'd1, 5'd2, 16'hFFFF), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("addi_imm_sext", out_imm, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h204, enc_i(OpOri, 5'd1, 5'd3, 16'h8000), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      settle();
      chk("bp_ready", 32'(in_ready), 32'd0);
      clock();
      chk("bp_hold_pc", out_pc, 32'h200);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    drive(1'b1, 32'h204, enc_i(OpOri, 5'd1, 5'd3, 16'h8000), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    clock();
    chk("bp_resume_pc", out_pc, 32'h204);
    chk("ori_imm_zext", out_imm, 32'h0000_8000);

    // Flush with a valid input, then jal
    drive(1'b1, 32'h300, enc_r(5'd1, 5'd2, 5'd3, FnAdd), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("flush_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h304, {OpJal, 26'h0000ABC}, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("jal_dest", 32'(out_dest), 32'd31);
    chk("jal_link", 32'(out_ctrl.link), 32'd1);

    // Write to r0 is ignored
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1);
    settle();
    clock();
    drive(1'b1, 32'h308, enc_r(5'd1, 5'd0, 5'd0, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    chk("r0_no_stall", 32'(in_ready), 32'd1);
    clock();
    chk("r0_reads_zero", out_s1, 32'h0);
    drive(1'b1, 32'h30C, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    clock();
    chk("nop_flag", 32'(out_ctrl.nop), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 4) != 0), $urandom, rand_instr(), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 4), pick_wb_addr(), $urandom, ($urandom_range(0, 3) != 0));
      settle();
      clock();
    end

    // Reset while a load is being accepted
    drive(1'b1, 32'h400, enc_i(OpLw, 5'd0, 5'd6, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_sp", stack_pointer, SP_RST);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h404, enc_r(5'd7, 5'd6, 5'd6, FnAdd), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    settle();
    chk("arst_ready", 32'(in_ready), 32'd1);
    clock();
    chk("arst_accept", 32'(out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001 Parameter DATA_W, default 32: register and operand width.
- REQ-002 Parameter NUM_REGS, default 32: register count (power of two, 8..64); AW = log2(NUM_REGS).
- REQ-003 Parameter SP_IDX, default 29: stack-pointer register index.
- REQ-004 Parameter SP_RESET, default 32'h7FFF_FFF0: stack-pointer reset value, truncated to DATA_W.
- REQ-005 Parameter LINK_IDX, default NUM_REGS-1: link destination register.
- REQ-006 Port list, one port per line:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - in_valid  in  1  pc/instruction valid.
  - in_ready  out  1  stage accepts this cycle.
  - pc  in  32  instruction address.
  - instruction  in  32  raw instruction.
  - flush  in  1  discard held and accepted instruction.
  - wb_en  in  1  write-back strobe.
  - wb_addr  in  AW  write-back register.
  - wb_data  in  DATA_W  write-back value.
  - out_valid  out  1  decoded bundle valid.
  - out_ready  in  1  downstream accepts.
  - out_pc  out  32  registered pc.
  - out_s1  out  DATA_W  source 1 value (base for memory ops).
  - out_s2  out  DATA_W  source 2 (rt) value.
  - out_imm  out  DATA_W  immediate, sign- or zero-extended per sign_x.
  - out_dest  out  AW  destination: LINK_IDX if link, else rd if r_dst, else rt.
  - out_ctrl  out  CTRL_W  packed control bundle (package type).
  - stack_pointer  out  DATA_W  live value of register SP_IDX.

Function
- REQ-007 Latency one cycle: an accepted instruction appears on out_* on the next rising edge.
- REQ-008 in_ready = !stall && (!out_valid || out_ready); a transfer occurs on in_valid && in_ready.
- REQ-009 out_* hold stable while out_valid && !out_ready.
- REQ-010 Register 0 reads 0 always; writes to it are ignored.
- REQ-011 Scoreboard: one busy bit per register.
  - Set on transfer of a load with nonzero dest.
  - Cleared on wb_en to that address.
  - Same-cycle set and clear of one address: set wins.
- REQ-012 stall asserts when any used source (s1, or s2 if the instruction reads rt) has its busy bit set and that bit is not cleared by wb in the same cycle.
- REQ-013 flush forces out_valid to 0 next cycle, blocks same-cycle acceptance, and leaves register file and scoreboard unchanged.
- REQ-014 Write-back occurs on the rising edge when wb_en is set; the written value is visible to reads from the next cycle.
- REQ-015 stack_pointer reflects the register file contents with no bypass.
- REQ-016 nop instructions are passed through with out_ctrl.nop=1 and never set the scoreboard.

Reset
- REQ-017 On rst_n low, asynchronously:
  - out_valid=0, out_pc=0, out_s1=0, out_s2=0, out_imm=0, out_dest=0, out_ctrl=0.
  - Scoreboard cleared.
  - All registers 0, except SP_IDX=SP_RESET.
- REQ-018 Reset mid-transfer discards the in-flight instruction; in_ready is 1 on the first edge after release.

Configuration
- REQ-019 DECODE_WB_BYPASS_EN defined: a same-cycle wb_addr match on a source supplies wb_data to that operand, and the REQ-012 same-cycle clear releases the stall.
- REQ-020 DECODE_WB_BYPASS_EN undefined: operands read stored values only, and the stall persists until the cycle after the busy bit clears.

Structure
- REQ-021 Package decode_pkg holds:
  - the ctrl_t struct: alu_op[5:0], access_size, byte_s, alu_in_b, d_mem_we, rwd, br, jp, g_t, sign_x, nop, mem_op, link, rwe, r_dst, uses_rt, is_load;
  - CTRL_W;
  - opcode constants.
- REQ-022 Combinational sub-module instr_decoder maps instruction to fields and ctrl_t; decode_stage owns the register file, scoreboard, handshake and output register.

Verification
- REQ-023 Reset release:
  - stack_pointer=32'h7FFF_FFF0.
  - Reading register 5 gives 0.
  - out_valid=0, in_ready=1.
- REQ-024 wb r8=0x1234 at cycle N, then "add r9,r8,r8" accepted at N+1: out_s1=out_s2=0x1234 at N+2.
- REQ-025 "lw r4,0(r2)" then "add r5,r4,r1":
  - in_ready=0 until wb r4=0xAA.
  - With bypass: the add is accepted in the wb cycle with out_s1=0xAA.
  - Without bypass: the add is accepted one cycle later.
- REQ-026 out_ready=0 for 3 cycles with out_valid=1: out_* unchanged and in_ready=0; transfer resumes when out_ready rises.
- REQ-027 flush together with in_valid: no transfer, and out_valid=0 next cycle; jal sets out_dest=LINK_IDX (31).
- REQ-028 wb r0=0xFFFF: a subsequent read of r0 returns 0, and no stall on r0.
